// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_W        = 8;
  localparam int unsigned UART_RX_FIFO_DEPTH = 4;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    COMMIT  = 1'b1
  } RX_FRAME_STATE_e;

  // FIFO entry layout, MSB first: frame_err, parity_err, data
  typedef struct packed {
    logic                   frame_err;
    logic                   parity_err;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Host read port of the UART receive buffer (valid/ready, FWFT head).
interface uart_rx_buffer_if #(
  parameter int unsigned DATA_W = 8
);
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_parity_err;
  logic              rd_frame_err;

  modport master (
    output rd_valid,
    output rd_data,
    output rd_parity_err,
    output rd_frame_err,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    input  rd_parity_err,
    input  rd_frame_err,
    output rd_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// The head word is presented combinationally and reads as zero while empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Accept decisions; a full FIFO makes room when the head leaves this cycle.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = empty ? '0 : mem[rd_ptr];
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers (wrap naturally at power-of-two depth) and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: shifts in data bits on FSM strobes, checks parity and
// the stop bit, and commits each frame with its error flags into a FWFT FIFO.
// Optional build macro UART_RX_ERR_DISCARD_EN: frames with any error are
// dropped instead of stored, and err_cnt counts them (saturating).
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = UART_DATA_W,
  parameter int unsigned FIFO_DEPTH = UART_RX_FIFO_DEPTH,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  input  logic                        ovf,
  input  logic                        enb_sipo,
  input  logic                        enb_parity,
  input  logic                        rx_interrupt,
  input  logic                        clr_flags,
  uart_rx_buffer_if.master            rd,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef UART_RX_ERR_DISCARD_EN
  ,
  output logic [7:0]                  err_cnt
`endif
);

  localparam int unsigned CNT_W   = $clog2(DATA_W + 1);
  localparam int unsigned ENTRY_W = DATA_W + 2;

  RX_FRAME_STATE_e   state;
  logic [DATA_W-1:0] sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic              par_bit;
  logic              stop_bad;
  logic              short_frame;

  logic               parity_err;
  logic               frame_err;
  logic               commit;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] head;

  // Frame verdict and FIFO handshake, evaluated during the COMMIT cycle.
  always_comb begin
    parity_err = (par_bit != (^sr ^ PARITY_ODD));
    frame_err  = stop_bad | short_frame;
    commit     = (state == COMMIT);
`ifdef UART_RX_ERR_DISCARD_EN
    push       = commit && !(parity_err || frame_err);
`else
    push       = commit;
`endif
    pop        = rd.rd_valid && rd.rd_ready;
  end

  // Frame collection: shift data bits, capture parity, latch stop verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      sr          <= '0;
      bit_cnt     <= '0;
      par_bit     <= 1'b0;
      stop_bad    <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (enb_sipo && ovf) begin
            sr <= {rx, sr[DATA_W-1:1]};
            if (bit_cnt != CNT_W'(DATA_W)) bit_cnt <= bit_cnt + CNT_W'(1);
          end
          if (enb_parity && ovf) par_bit <= rx;
          if (rx_interrupt && ovf) begin
            stop_bad    <= ~rx;
            short_frame <= (bit_cnt != CNT_W'(DATA_W));
            state       <= COMMIT;
          end
        end
        COMMIT: begin
          sr      <= '0;
          bit_cnt <= '0;
          state   <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // Sticky overrun; a new loss in the same cycle as clr_flags keeps it set.
  always_ff @(posedge clk) begin
    if (rst)                           overrun <= 1'b0;
    else if (push && full && !pop)     overrun <= 1'b1;
    else if (clr_flags)                overrun <= 1'b0;
  end

`ifdef UART_RX_ERR_DISCARD_EN
  // Saturating count of frames dropped for parity or framing errors.
  always_ff @(posedge clk) begin
    if (rst || clr_flags) err_cnt <= '0;
    else if (commit && (parity_err || frame_err) && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end
`endif

  // Entries use the rx_entry_t layout, sized by DATA_W.
  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({frame_err, parity_err, sr}),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .count (fifo_count)
  );

  assign rd.rd_valid = !empty;
  assign {rd.rd_frame_err, rd.rd_parity_err, rd.rd_data} = head;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: directed frames with literal
// expectations, then randomized frames checked every cycle against a
// queue-based model of the frame/FIFO behaviour.
module tb_uart_rx_buffer;
  import uart_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam bit          ODD   = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, rx = 1'b1, ovf = 1'b0, enb_sipo = 1'b0, enb_parity = 1'b0;
  logic rx_interrupt = 1'b0, clr_flags = 1'b0, rd_ready = 1'b0;
  logic overrun;
  logic [2:0] fifo_count;
`ifdef UART_RX_ERR_DISCARD_EN
  logic [7:0] err_cnt;
`endif

  uart_rx_buffer_if #(.DATA_W(DW)) rd_if ();
  assign rd_if.rd_ready = rd_ready;

  uart_rx_buffer #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .PARITY_ODD (ODD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .ovf          (ovf),
    .enb_sipo     (enb_sipo),
    .enb_parity   (enb_parity),
    .rx_interrupt (rx_interrupt),
    .clr_flags    (clr_flags),
    .rd           (rd_if),
    .overrun      (overrun),
    .fifo_count   (fifo_count)
`ifdef UART_RX_ERR_DISCARD_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } ent_t;

  ent_t mq[$];
  bit   bits_q[$];
  logic m_par = 1'b0, m_pend = 1'b0, m_stop_bad = 1'b0, m_ovr = 1'b0;
  int   m_err = 0;
  ent_t e;
  int   nb;
  bit   ovr_ev;

  // Model update from the inputs the DUT samples at this edge.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); bits_q.delete();
      m_par = 1'b0; m_pend = 1'b0; m_stop_bad = 1'b0; m_ovr = 1'b0; m_err = 0;
    end else begin
      ovr_ev = 1'b0;
      if (mq.size() != 0 && rd_ready) void'(mq.pop_front());
      if (m_pend) begin
        // data = last (up to) DW received bits, most recent at the MSB
        nb = bits_q.size();
        e.d = 8'h00;
        for (int j = 0; j < nb && j < 8; j++) e.d[7-j] = bits_q[nb-1-j];
        e.pe = (m_par != (^e.d ^ ODD));
        e.fe = m_stop_bad || (nb < 8);
        m_pend = 1'b0;
        bits_q.delete();
`ifdef UART_RX_ERR_DISCARD_EN
        if (e.pe || e.fe) begin
          if (m_err < 255) m_err++;
        end else if (mq.size() < DEPTH) mq.push_back(e);
        else ovr_ev = 1'b1;
`else
        if (mq.size() < DEPTH) mq.push_back(e);
        else ovr_ev = 1'b1;
`endif
      end else begin
        if (enb_sipo && ovf)     bits_q.push_back(rx);
        if (enb_parity && ovf)   m_par = rx;
        if (rx_interrupt && ovf) begin m_pend = 1'b1; m_stop_bad = !rx; end
      end
      if (ovr_ev) m_ovr = 1'b1;
      else if (clr_flags) m_ovr = 1'b0;
`ifdef UART_RX_ERR_DISCARD_EN
      if (clr_flags) m_err = 0;
`endif
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("rd_valid", 32'(rd_if.rd_valid), 32'(mq.size() != 0));
    chk("rd_data", 32'(rd_if.rd_data), (mq.size() != 0) ? 32'(mq[0].d) : 32'd0);
    chk("rd_parity_err", 32'(rd_if.rd_parity_err), (mq.size() != 0) ? 32'(mq[0].pe) : 32'd0);
    chk("rd_frame_err", 32'(rd_if.rd_frame_err), (mq.size() != 0) ? 32'(mq[0].fe) : 32'd0);
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("overrun", 32'(overrun), 32'(m_ovr));
`ifdef UART_RX_ERR_DISCARD_EN
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
  end

  // ---------------- stimulus ----------------
  bit rand_rdy = 1'b0;

  task automatic tick();
    @(posedge clk); #1;
    if (rand_rdy) rd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse(input int gap);
    repeat (gap) tick();
    ovf = 1'b1; tick(); ovf = 1'b0;
  endtask

  // Returns one cycle after the stop sample (the COMMIT cycle).
  task automatic send_frame(input logic [7:0] d, input int nbits, input logic par,
                            input logic stop, input int gap);
    enb_sipo = 1'b1;
    for (int i = 0; i < nbits; i++) begin rx = d[i % 8]; pulse(gap); end
    enb_sipo = 1'b0; enb_parity = 1'b1; rx = par; pulse(gap); enb_parity = 1'b0;
    rx_interrupt = 1'b1; rx = stop; pulse(gap); rx_interrupt = 1'b0; rx = 1'b1;
  endtask

  function automatic logic gp(input logic [7:0] d);
    return ^d ^ ODD;
  endfunction

  task automatic pop1();
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int r;

    repeat (3) tick();
    chk("reset_valid", 32'(rd_if.rd_valid), 32'd0);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_data", 32'(rd_if.rd_data), 32'd0);
    rst = 1'b0; tick();

    send_frame(8'hA5, 8, 1'b0, 1'b1, 2);
    chk("a5_not_yet_visible", 32'(rd_if.rd_valid), 32'd0);
    tick();
    chk("a5_valid", 32'(rd_if.rd_valid), 32'd1);
    chk("a5_data", 32'(rd_if.rd_data), 32'hA5);
    chk("a5_pe", 32'(rd_if.rd_parity_err), 32'd0);
    chk("a5_fe", 32'(rd_if.rd_frame_err), 32'd0);
    chk("a5_count", 32'(fifo_count), 32'd1);
    pop1();
    chk("a5_popped", 32'(fifo_count), 32'd0);

`ifndef UART_RX_ERR_DISCARD_EN
    send_frame(8'h3C, 8, 1'b1, 1'b1, 1); tick();
    chk("3c_data", 32'(rd_if.rd_data), 32'h3C);
    chk("3c_pe", 32'(rd_if.rd_parity_err), 32'd1);
    chk("3c_fe", 32'(rd_if.rd_frame_err), 32'd0);
    pop1();
    send_frame(8'h01, 8, 1'b1, 1'b0, 1); tick();
    chk("01_data", 32'(rd_if.rd_data), 32'h01);
    chk("01_fe", 32'(rd_if.rd_frame_err), 32'd1);
    chk("01_pe", 32'(rd_if.rd_parity_err), 32'd0);
    pop1();
    // 5 bits of 0x5A land in sr[7:3] -> 0xD0, odd popcount -> parity 1
    send_frame(8'h5A, 5, 1'b1, 1'b1, 1); tick();
    chk("short_data", 32'(rd_if.rd_data), 32'hD0);
    chk("short_fe", 32'(rd_if.rd_frame_err), 32'd1);
    chk("short_pe", 32'(rd_if.rd_parity_err), 32'd0);
    pop1();
`else
    send_frame(8'h11, 8, 1'b1, 1'b1, 1);
    send_frame(8'h22, 8, 1'b0, 1'b1, 1); tick();
    chk("discard_count", 32'(fifo_count), 32'd1);
    chk("discard_data", 32'(rd_if.rd_data), 32'h22);
    chk("discard_err_cnt", 32'(err_cnt), 32'd1);
    pop1();
`endif

    for (int k = 0; k < 5; k++) send_frame(8'(8'h10 + k), 8, gp(8'(8'h10 + k)), 1'b1, 1);
    tick();
    chk("ovr_count", 32'(fifo_count), 32'd4);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_head", 32'(rd_if.rd_data), 32'h10);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);

    send_frame(8'h55, 8, gp(8'h55), 1'b1, 1);
    pop1();
    chk("fullpop_count", 32'(fifo_count), 32'd4);
    chk("fullpop_overrun", 32'(overrun), 32'd0);
    chk("fullpop_head", 32'(rd_if.rd_data), 32'h11);
    for (int k = 0; k < 4; k++) begin
      d = (k == 3) ? 8'h55 : 8'(8'h11 + k);
      chk("fullpop_order", 32'(rd_if.rd_data), 32'(d));
      pop1();
    end

    enb_sipo = 1'b1;
    for (int i = 0; i < 4; i++) begin rx = 1'b1; pulse(1); end
    enb_sipo = 1'b0; rst = 1'b1; tick(); rst = 1'b0; tick();
    send_frame(8'h7E, 8, gp(8'h7E), 1'b1, 1); tick();
    chk("midrst_count", 32'(fifo_count), 32'd1);
    chk("midrst_data", 32'(rd_if.rd_data), 32'h7E);
    chk("midrst_flags", 32'({rd_if.rd_frame_err, rd_if.rd_parity_err}), 32'd0);
    pop1();

    rand_rdy = 1'b1;
    for (int f = 0; f < 150; f++) begin
      d = 8'($urandom);
      r = int'($urandom_range(0, 9));
      send_frame(d, (r == 0) ? 6 : (r == 1) ? 9 : 8, gp(d) ^ (r == 2), (r != 3),
                 int'($urandom_range(1, 3)));
      clr_flags = ($urandom_range(0, 7) == 0);
      tick();
      clr_flags = 1'b0;
      repeat (int'($urandom_range(0, 2))) tick();
    end
    rand_rdy = 1'b0; rd_ready = 1'b0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
